// File: rtl/bullet_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bullet_pkg : shared defaults, direction encoding, priority helper |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bullet_pkg;

  localparam int X_W_DEF      = 10;
  localparam int Y_W_DEF      = 9;
  localparam int Y_TOP_DEF    = 10;
  localparam int Y_BOT_DEF    = 470;
  localparam int PLAYER_Y_DEF = 450;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest supported pool; narrower masks are zero-extended by the caller.
  localparam int MASK_W = 16;

  function automatic logic [3:0] lowest_set(input logic [MASK_W-1:0] mask);
    logic [3:0] idx;
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bullet_slot : one bullet's state with load, move and retire logic |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int SPEED = 1,
  parameter int Y_TOP = Y_TOP_DEF,
  parameter int Y_BOT = Y_BOT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           load_up_i,
  input  logic [X_W-1:0] load_x_i,
  input  logic [Y_W-1:0] load_y_i,
  input  logic           move_i,
  input  logic           kill_i,
  output logic           active_o,
  output logic           up_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  localparam logic [Y_W:0] TOP_LIM = (Y_W+1)'(Y_TOP + SPEED);
  localparam logic [Y_W:0] BOT_LIM = (Y_W+1)'(Y_BOT);

  logic           active_q, active_d;
  logic           up_q, up_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W:0]   y_ext, y_dn;

  // One extra bit keeps the downward limit compare free of wrap-around.
  assign y_ext = {1'b0, y_q};
  assign y_dn  = y_ext + (Y_W+1)'(SPEED);

  always_comb begin
    active_d = active_q;
    up_d     = up_q;
    x_d      = x_q;
    y_d      = y_q;
    if (load_i) begin
      active_d = 1'b1;
      up_d     = load_up_i;
      x_d      = load_x_i;
      y_d      = load_y_i;
    end else if (active_q) begin
      if (kill_i) begin
        active_d = 1'b0;
      end else if (move_i) begin
        if (up_q == DIR_UP) begin
          if (y_ext < TOP_LIM) active_d = 1'b0;
          else                 y_d = y_q - Y_W'(SPEED);
        end else begin
          if (y_dn > BOT_LIM) active_d = 1'b0;
          else                y_d = y_dn[Y_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      up_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      up_q     <= up_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active_o = active_q;
  assign up_o     = up_q;
  assign x_o      = x_q;
  assign y_o      = y_q;

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bullet_pool : multi-slot bullet engine, slot allocation and acks  |
// | Option macro: PLAYER_SINGLE_SHOT_EN (one live player bullet max)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int SPEED     = 1,
  parameter int Y_TOP     = Y_TOP_DEF,
  parameter int Y_BOT     = Y_BOT_DEF,
  parameter int PLAYER_Y  = PLAYER_Y_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     move_tick,
  input  logic                     fire_player,
  input  logic                     fire_alien,
  input  logic [X_W-1:0]           player_x,
  input  logic [X_W-1:0]           alien_x,
  input  logic [Y_W-1:0]           alien_y,
  input  logic [NUM_SLOTS-1:0]     kill,
  output logic                     ack_player,
  output logic                     ack_alien,
  output logic [NUM_SLOTS-1:0]     slot_active,
  output logic [NUM_SLOTS-1:0]     slot_up,
  output logic [NUM_SLOTS*X_W-1:0] bullet_x,
  output logic [NUM_SLOTS*Y_W-1:0] bullet_y
);

  logic [MASK_W-1:0] free_m, free_after_m;
  logic [3:0]        p_idx, a_idx;
  logic              player_block, player_ok, alien_ok;
  logic              ack_player_q, ack_alien_q;

  // Free slots come from the registered state only, so a slot retired
  // this cycle cannot be reallocated until the following cycle.
  always_comb begin
    free_m = '0;
    for (int i = 0; i < NUM_SLOTS; i++) free_m[i] = ~slot_active[i];
  end

`ifdef PLAYER_SINGLE_SHOT_EN
  assign player_block = |(slot_active & slot_up);
`else
  assign player_block = 1'b0;
`endif

  assign player_ok = fire_player & ~player_block & (|free_m);
  assign p_idx     = lowest_set(free_m);

  always_comb begin
    free_after_m = free_m;
    if (player_ok) free_after_m[p_idx] = 1'b0;
  end

  assign alien_ok = fire_alien & (|free_after_m);
  assign a_idx    = lowest_set(free_after_m);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_player_q <= 1'b0;
      ack_alien_q  <= 1'b0;
    end else begin
      ack_player_q <= player_ok;
      ack_alien_q  <= alien_ok;
    end
  end

  assign ack_player = ack_player_q;
  assign ack_alien  = ack_alien_q;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic           sel_p, sel_a;
    logic [X_W-1:0] ld_x;
    logic [Y_W-1:0] ld_y;

    assign sel_p = player_ok && (p_idx == 4'(i));
    assign sel_a = alien_ok  && (a_idx == 4'(i));
    assign ld_x  = sel_p ? player_x : alien_x;
    assign ld_y  = sel_p ? Y_W'(PLAYER_Y) : alien_y;

    bullet_slot #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .SPEED (SPEED),
      .Y_TOP (Y_TOP),
      .Y_BOT (Y_BOT)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load_i    (sel_p | sel_a),
      .load_up_i (sel_p ? DIR_UP : DIR_DOWN),
      .load_x_i  (ld_x),
      .load_y_i  (ld_y),
      .move_i    (move_tick),
      .kill_i    (kill[i]),
      .active_o  (slot_active[i]),
      .up_o      (slot_up[i]),
      .x_o       (bullet_x[i*X_W +: X_W]),
      .y_o       (bullet_y[i*Y_W +: Y_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bullet_pool : directed and random checks against a slot model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_bullet_pool;

  localparam int NS  = 4;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int SPD = 1;
  localparam int YT  = 10;
  localparam int YB  = 470;
  localparam int PY  = 450;

  logic           clk, reset, move_tick, fire_player, fire_alien;
  logic [XW-1:0]  player_x, alien_x;
  logic [YW-1:0]  alien_y;
  logic [NS-1:0]  kill;
  logic           ack_player, ack_alien;
  logic [NS-1:0]  slot_active, slot_up;
  logic [NS*XW-1:0] bullet_x;
  logic [NS*YW-1:0] bullet_y;

  bullet_pool #(
    .NUM_SLOTS(NS), .X_W(XW), .Y_W(YW), .SPEED(SPD),
    .Y_TOP(YT), .Y_BOT(YB), .PLAYER_Y(PY)
  ) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick),
    .fire_player(fire_player), .fire_alien(fire_alien),
    .player_x(player_x), .alien_x(alien_x), .alien_y(alien_y),
    .kill(kill), .ack_player(ack_player), .ack_alien(ack_alien),
    .slot_active(slot_active), .slot_up(slot_up),
    .bullet_x(bullet_x), .bullet_y(bullet_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_act[NS], m_up[NS], m_x[NS], m_y[NS];
  int m_ackp, m_acka;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int dx(input int s);
    return int'(bullet_x[s*XW +: XW]);
  endfunction

  function automatic int dy(input int s);
    return int'(bullet_y[s*YW +: YW]);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_act[s] = 0; m_up[s] = 0; m_x[s] = 0; m_y[s] = 0;
    end
    m_ackp = 0; m_acka = 0;
  endtask

  // Next state from the game rules: pick free slots, then fly or retire.
  task automatic model_next(input bit fp, input bit fa, input int px,
                            input int ax, input int ay, input int k, input bit mt);
    int pslot, aslot;
    bit blocked;
    pslot = -1; aslot = -1; blocked = 0;
`ifdef PLAYER_SINGLE_SHOT_EN
    for (int s = 0; s < NS; s++) if (m_act[s] == 1 && m_up[s] == 1) blocked = 1;
`endif
    if (fp && !blocked)
      for (int s = NS - 1; s >= 0; s--) if (m_act[s] == 0) pslot = s;
    if (fa)
      for (int s = NS - 1; s >= 0; s--) if (m_act[s] == 0 && s != pslot) aslot = s;
    for (int s = 0; s < NS; s++) begin
      if (s == pslot) begin
        m_act[s] = 1; m_up[s] = 1; m_x[s] = px; m_y[s] = PY;
      end else if (s == aslot) begin
        m_act[s] = 1; m_up[s] = 0; m_x[s] = ax; m_y[s] = ay;
      end else if (m_act[s] == 1) begin
        if (k[s]) m_act[s] = 0;
        else if (mt) begin
          if (m_up[s] == 1) begin
            if (m_y[s] - SPD < YT) m_act[s] = 0;
            else m_y[s] = m_y[s] - SPD;
          end else begin
            if (m_y[s] + SPD > YB) m_act[s] = 0;
            else m_y[s] = m_y[s] + SPD;
          end
        end
      end
    end
    m_ackp = (pslot >= 0) ? 1 : 0;
    m_acka = (aslot >= 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("active[%0d]", s), int'(slot_active[s]), m_act[s]);
      chk($sformatf("up[%0d]", s),     int'(slot_up[s]),     m_up[s]);
      chk($sformatf("x[%0d]", s),      dx(s),                m_x[s]);
      chk($sformatf("y[%0d]", s),      dy(s),                m_y[s]);
    end
    chk("ack_player", int'(ack_player), m_ackp);
    chk("ack_alien",  int'(ack_alien),  m_acka);
  endtask

  task automatic step(input bit fp, input bit fa, input int px, input int ax,
                      input int ay, input int k, input bit mt);
    fire_player = fp;
    fire_alien  = fa;
    player_x    = XW'(px);
    alien_x     = XW'(ax);
    alien_y     = YW'(ay);
    kill        = NS'(k);
    move_tick   = mt;
    model_next(fp, fa, px, ax, ay, k, mt);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    fire_player = 0; fire_alien = 0; move_tick = 0; kill = '0;
    player_x = '0; alien_x = '0; alien_y = '0;
  endtask

  // Asynchronous reset pulsed between clock edges.
  task automatic async_reset();
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset = 1'b1;
    #1;
    chk("reset_active", int'(slot_active), 0);
    chk("reset_acks", int'({ack_player, ack_alien}), 0);
    compare_all();
    #12;
    reset = 1'b0;

    // Single player shot, then three moves.
    step(1, 0, 320, 0, 0, 0, 0);
    chk("p_active0", int'(slot_active[0]), 1);
    chk("p_up0", int'(slot_up[0]), 1);
    chk("p_x0", dx(0), 320);
    chk("p_y0", dy(0), 450);
    chk("p_ack", int'(ack_player), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("p_ack_pulse", int'(ack_player), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("p_y_after3", dy(0), 447);

    // Simultaneous requests, then fill the pool.
    async_reset();
    step(1, 1, 200, 100, 50, 0, 0);
    chk("both_active", int'(slot_active), 3);
    chk("both_acks", int'({ack_player, ack_alien}), 3);
    chk("alien_x1", dx(1), 100);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("alien_y1_tick", dy(1), 51);
    step(0, 1, 0, 300, 60, 0, 0);
    chk("three_active", int'(slot_active), 7);
    step(1, 1, 77, 88, 99, 0, 0);
    chk("last_slot_player", int'(slot_up[3]), 1);
    chk("last_slot_ackp", int'(ack_player), 1);
    chk("last_slot_no_acka", int'(ack_alien), 0);
    step(1, 0, 5, 0, 0, 0, 0);
    chk("full_no_ack", int'(ack_player), 0);
    chk("full_active", int'(slot_active), 15);

    // Boundary retirements.
    async_reset();
    step(1, 0, 7, 0, 0, 0, 0);
    for (int i = 0; i < 440; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("top_y10", dy(0), 10);
    chk("top_still_active", int'(slot_active[0]), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("top_retired", int'(slot_active[0]), 0);
    chk("top_y_kept", dy(0), 10);
    step(0, 1, 0, 11, 469, 0, 0);
    chk("alien469_slot0", dy(0), 469);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("alien470_active", int'(slot_active[0]), 1);
    chk("alien470_y", dy(0), 470);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("alien_retired", int'(slot_active[0]), 0);
    chk("alien_y_kept", dy(0), 470);

    // Kill beats movement; killed slot not reusable the same cycle.
    async_reset();
    step(1, 1, 5, 100, 50, 0, 0);
    step(1, 0, 33, 0, 0, 2, 1);
    chk("kill_active", int'(slot_active), 5);
    chk("kill_y_kept", dy(1), 50);
    chk("kill_fire_slot2", dx(2), 33);
    step(1, 0, 44, 0, 0, 0, 0);
    chk("reuse_slot1", int'(slot_active), 7);
    chk("reuse_slot1_y", dy(1), 450);

    // Randomized traffic with occasional asynchronous resets.
    async_reset();
    for (int c = 0; c < 3000; c++) begin
      bit fp, fa, mt;
      int k;
      fp = ($urandom % 4) == 0;
      fa = ($urandom % 4) == 0;
      mt = ($urandom % 2) == 0;
      k  = (($urandom % 6) == 0) ? int'($urandom % 16) : 0;
      step(fp, fa, int'($urandom % 1024), int'($urandom % 1024),
           (($urandom % 3) == 0) ? int'(460 + $urandom % 52) : int'($urandom % 512),
           k, mt);
      if ((c % 700) == 699) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
